mem_port_arbiter: RTL

//  Shares the single unified instruction/data memory between two requesters:
//  the multicycle core's memory port (fetch/LW/SW) and the program loader
//  (boot image write / debug readback). Sits between both masters and the

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/arb_rr2.sv | 21 ++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the core/loader memory port arbiter.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_LDR  = 1'b1;

  // Wait counter width; kept at least 1 bit so a zero-latency build still elaborates.
  function automatic int unsigned wait_cnt_w(input int unsigned wc);
    return (wc == 0) ? 1 : $clog2(wc + 1);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-input round-robin picker; the last-grant history is kept by the caller.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_c,
  output logic       valid_c
);

  always_comb begin
    valid_c = |req;
    grant_c = REQ_CORE;
    case (req)
      2'b10:   grant_c = REQ_LDR;
      2'b11:   grant_c = ~last_grant;
      default: grant_c = REQ_CORE;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory macro between the core port and the program loader,
// sequencing each access as IDLE -> ACCESS -> WAIT -> RESP.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW          = 8,
  parameter int unsigned DW          = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_ack,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned CW = wait_cnt_w(WAIT_CYCLES);

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last_grant;
  logic          cur_id;
  logic          cur_we;
  logic          gnt_id_c, gnt_valid_c;
  logic          start_c, enter_resp_c, capture_c;
  logic          sel_we_c;
  logic [AW-1:0] sel_addr_c;
  logic [DW-1:0] sel_wdata_c;

  arb_rr2 u_arb (
    .req        ({ldr_req, core_req}),
    .last_grant (last_grant),
    .grant_c    (gnt_id_c),
    .valid_c    (gnt_valid_c)
  );

  // Next state, wait countdown and per-cycle strobes.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    sel_we_c     = (gnt_id_c == REQ_LDR) ? ldr_we    : core_we;
    sel_addr_c   = (gnt_id_c == REQ_LDR) ? ldr_addr  : core_addr;
    sel_wdata_c  = (gnt_id_c == REQ_LDR) ? ldr_wdata : core_wdata;
    start_c      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gnt_valid_c) begin
          start_c   = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (WAIT_CYCLES == 0) begin
          state_nxt = ST_RESP;
        end else begin
          state_nxt = ST_WAIT;
          cnt_nxt   = CW'(WAIT_CYCLES);
        end
      end
      ST_WAIT: begin
        if (cnt <= CW'(1)) state_nxt = ST_RESP;
        else               cnt_nxt   = cnt - CW'(1);
      end
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    enter_resp_c = (state_nxt == ST_RESP) && (state != ST_RESP);
    // Read data is taken on the edge that closes the last memory-latency cycle.
    capture_c    = enter_resp_c && !cur_we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      last_grant <= REQ_LDR;
      cur_id     <= REQ_CORE;
      cur_we     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_ack   <= 1'b0;
      ldr_ack    <= 1'b0;
      core_rdata <= '0;
      ldr_rdata  <= '0;
      busy       <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      busy     <= (state_nxt != ST_IDLE);
      mem_en   <= start_c;
      mem_we   <= start_c && sel_we_c;
      core_ack <= enter_resp_c && (cur_id == REQ_CORE);
      ldr_ack  <= enter_resp_c && (cur_id == REQ_LDR);
      if (start_c) begin
        cur_id     <= gnt_id_c;
        last_grant <= gnt_id_c;
        cur_we     <= sel_we_c;
        mem_addr   <= sel_addr_c;
        mem_wdata  <= sel_wdata_c;
      end
      if (capture_c && (cur_id == REQ_CORE)) core_rdata <= mem_rdata;
      if (capture_c && (cur_id == REQ_LDR))  ldr_rdata  <= mem_rdata;
    end
  end

endmodule
